// File: rtl/switch_out_port_if.sv
// switch_out_port_if: switch-side ingress, link-side egress and status signals of one egress port.
interface switch_out_port_if #(
    parameter int FCW = 85,
    parameter int OW  = 4
);
    logic [FCW-1:0] sw_in;
    logic           sw_in_valid;
    logic           out_avail;
    logic [FCW-1:0] link_out;
    logic           link_valid;
    logic           credit_ret;
    logic           overflow_err;
    logic [OW-1:0]  occupancy;

    modport slave (
        input  sw_in, sw_in_valid, credit_ret,
        output out_avail, link_out, link_valid, overflow_err, occupancy
    );

    modport master (
        output sw_in, sw_in_valid, credit_ret,
        input  out_avail, link_out, link_valid, overflow_err, occupancy
    );
endinterface

// File: rtl/switch_out_port.sv
// switch_out_port: FIFO-buffered egress stage from a switch output slice to a credit-flow-controlled link.
module switch_out_port #(
    parameter int ValidBitPos  = 81,
    parameter int lg_numprocs  = 3,
    parameter int DEPTH        = 8,
    parameter int LINK_CREDITS = 4,
    parameter int STALL_MARGIN = 2
) (
    input logic               clk,
    input logic               rst,
    switch_out_port_if.slave  bus
);
    localparam int FCW = ValidBitPos + 1 + lg_numprocs;
    localparam int AW  = $clog2(DEPTH);
    localparam int OW  = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [FCW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [3:0]       credits_q, credits_d;
    logic [4:0]       credits_sum;
    logic [FCW-1:0]   link_out_q, link_out_d;
    logic             out_avail_q, out_avail_d;
    logic             overflow_q, overflow_d;
    logic             push, push_ok, pop, full;

    always_comb begin
        full        = occ_q == OW'(DEPTH);
        pop         = (occ_q != '0) && (credits_q != '0);
        push        = bus.sw_in_valid && bus.sw_in[ValidBitPos];
        // a pop in the same cycle frees the slot, so a full FIFO can still accept
        push_ok     = push && (!full || pop);
        wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d       = occ_q + OW'(push_ok) - OW'(pop);
        out_avail_d = (OW'(DEPTH) - occ_d) <= OW'(STALL_MARGIN);
        overflow_d  = overflow_q || (push && !push_ok);
        credits_sum = {1'b0, credits_q} + 5'(bus.credit_ret) - 5'(pop);
        credits_d   = credits_sum > 5'(LINK_CREDITS) ? 4'(LINK_CREDITS) : credits_sum[3:0];
        link_out_d  = pop ? mem_q[rd_ptr_q] : link_out_q;
    end

    always_comb begin
        state_d = pop ? SEND : IDLE;
    end

    always_comb begin
        bus.link_valid   = state_q == SEND;
        bus.link_out     = link_out_q;
        bus.out_avail    = out_avail_q;
        bus.overflow_err = overflow_q;
        bus.occupancy    = occ_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            credits_q   <= 4'(LINK_CREDITS);
            link_out_q  <= '0;
            out_avail_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            credits_q   <= credits_d;
            link_out_q  <= link_out_d;
            out_avail_q <= out_avail_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_ok) mem_q[wr_ptr_q] <= bus.sw_in;
    end
endmodule
